// File: rtl/risc_pkg.sv
// Shared RISC definitions: default bus widths, opcodes and memory-arbiter state encoding.
package risc_pkg;

  localparam int unsigned AWIDTH_DEF = 5;
  localparam int unsigned DWIDTH_DEF = 8;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

endpackage

// File: rtl/risc_sat_counter.sv
// Saturating up-counter with synchronous clear; sat_c flags the terminal count.
module risc_sat_counter #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned CW       = $clog2(MAX_WAIT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          sat_c
);

  assign sat_c = (cnt == CW'(MAX_WAIT));

  // Clear has priority over increment; counting stops at MAX_WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat_c) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/risc_mem_arbiter.sv
// Single-port RAM arbiter: CPU has priority, debug port uses idle slots with bounded wait.
// Build option: define RISC_ARB_WPROT_EN to block debug writes while the core runs (adds dbg_err).
module risc_mem_arbiter
  import risc_pkg::*;
#(
  parameter int unsigned AWIDTH   = AWIDTH_DEF,
  parameter int unsigned DWIDTH   = DWIDTH_DEF,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              cpu_halt,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [AWIDTH-1:0] dbg_addr,
  input  logic [DWIDTH-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DWIDTH-1:0] dbg_rdata,
`ifdef RISC_ARB_WPROT_EN
  output logic              dbg_err,
`endif
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam int unsigned WCW = $clog2(MAX_WAIT + 1);

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic              cpu_access;
  logic              starve;
  logic              grant;
  logic              wait_inc;
  logic              dbg_wr_ok;
  logic              gnt_rd;
  logic              rd_ack;
  logic [DWIDTH-1:0] rdata_q;
  logic [WCW-1:0]    wait_cnt;

  assign cpu_access = cpu_rd | cpu_wr;
  assign cpu_rdata  = mem_rdata;

`ifdef RISC_ARB_WPROT_EN
  assign dbg_wr_ok = cpu_halt;
`else
  assign dbg_wr_ok = 1'b1;
`endif

  risc_sat_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CW       (WCW)
  ) u_wait (
    .clk   (clk),
    .rst_n (rst),
    .clr   (grant),
    .inc   (wait_inc),
    .cnt   (wait_cnt),
    .sat_c (starve)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Memory mux and grant decision; RAM strobes are forced low while reset is asserted
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    wait_inc  = 1'b0;
    cpu_stall = 1'b0;
    mem_rd    = cpu_rd & ~cpu_wr;
    mem_wr    = cpu_wr;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (!rst) begin
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end else begin
      case (state)
        ST_ACK: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          if (dbg_req && (!cpu_access || cpu_halt || starve)) begin
            grant     = 1'b1;
            cpu_stall = cpu_access;
            mem_rd    = ~dbg_we;
            mem_wr    = dbg_we & dbg_wr_ok;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            state_nxt = ST_ACK;
          end else begin
            wait_inc = dbg_req;
          end
        end
      endcase
    end
  end

  // Acknowledge and read-capture registers for the granted debug access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbg_ack <= 1'b0;
      gnt_rd  <= 1'b0;
      rdata_q <= '0;
    end else begin
      dbg_ack <= grant;
      gnt_rd  <= grant & ~dbg_we;
      if (rd_ack) begin
        rdata_q <= mem_rdata;
      end
    end
  end

`ifdef RISC_ARB_WPROT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbg_err <= 1'b0;
    end else begin
      dbg_err <= grant & dbg_we & ~cpu_halt;
    end
  end
`endif

  // RAM data arrives during the ack cycle, so present it directly and keep it afterwards
  assign rd_ack    = (state == ST_ACK) & gnt_rd;
  assign dbg_rdata = rd_ack ? mem_rdata : rdata_q;

endmodule

// File: doc/risc_mem_arbiter.md
Name: risc_mem_arbiter

Overview:
Arbitrates the single-port 32x8 program/data RAM between the RISC core (instruction fetch, LDA/ADD/AND/XOR operand reads, STO writes) and a debug/loader port. The debug port replaces back-door RAM pokes for program loading and inspection. The CPU has priority, and the debug port uses idle memory cycles. A bounded-wait counter stalls the CPU for one cycle so the debug port is never starved.

Parameters:
AWIDTH, 5, RAM address width (32 words)
DWIDTH, 8, RAM data width
MAX_WAIT, 8, debug wait cycles before CPU is stalled for one cycle (1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
cpu_rd  in  1  CPU read request this cycle
cpu_wr  in  1  CPU write request this cycle
cpu_addr  in  AWIDTH  CPU address
cpu_wdata  in  DWIDTH  CPU write data
cpu_rdata  out  DWIDTH  CPU read data (passthrough of mem_rdata)
cpu_stall  out  1  CPU access blocked this cycle; CPU holds request
cpu_halt  in  1  core halted (HLT executed)
dbg_req  in  1  debug request, level, held until dbg_ack
dbg_we  in  1  debug write (1) / read (0)
dbg_addr  in  AWIDTH  debug address
dbg_wdata  in  DWIDTH  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DWIDTH  registered debug read data, valid with dbg_ack
mem_rd  out  1  RAM read strobe
mem_wr  out  1  RAM write strobe
mem_addr  out  AWIDTH  RAM address
mem_wdata  out  DWIDTH  RAM write data
mem_rdata  in  DWIDTH  RAM read data, valid cycle after mem_rd

Behaviour:
- Reset (rst=0, async): state=IDLE, wait_cnt=0, dbg_ack=0, dbg_rdata=0, cpu_stall=0, mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0.
- cpu_access = cpu_rd | cpu_wr. If both are high, write wins and the read is dropped.
- FSM states: IDLE and ACK.
- IDLE, debug grant:
  - Condition: dbg_req & (!cpu_access | cpu_halt | starve), where starve = (wait_cnt==MAX_WAIT).
  - mem_* is driven combinationally from the dbg_* inputs.
  - If cpu_access is also high, cpu_stall=1.
  - Next state is ACK.
- IDLE, otherwise: mem_* is driven from cpu_* with zero latency; cpu_stall=0.
- wait_cnt:
  - Increments in IDLE while dbg_req is high and not granted; saturates at MAX_WAIT.
  - Clears on grant.
- ACK:
  - dbg_ack=1 for exactly one cycle.
  - dbg_rdata <= mem_rdata if the granted access was a read; otherwise holds its value.
  - CPU owns the memory this cycle and is not stalled.
  - Next state is IDLE.
- Debug handshake:
  - Requester drops dbg_req, or changes transaction, in the cycle after dbg_ack.
  - dbg_req still high in that cycle is a new transaction.
  - dbg_req sampled in ACK is ignored.
- Debug latency: minimum 1 cycle grant-to-ack. Worst case MAX_WAIT+1 cycles from request to grant.
- cpu_halt=1: debug is always granted immediately. The CPU issues no accesses while halted; any that occur are stalled.
- cpu_rdata = mem_rdata always. The CPU ignores it in cycles following a stall.
- Address/data are passed unmodified; no wrap logic. AWIDTH bounds the address.
- Reset mid-transaction: grant aborted, no dbg_ack. A write already strobed may have landed.

Optional Feature:
Macro RISC_ARB_WPROT_EN.
- Defined:
  - Debug writes with cpu_halt=0 are suppressed: mem_wr stays 0.
  - Extra output dbg_err (1 bit, reset 0) pulses with dbg_ack.
  - Debug reads are unaffected.
- Undefined: no dbg_err port; debug writes are always performed.

Decomposition:
- Shared package risc_pkg holds:
  - AWIDTH/DWIDTH defaults
  - opcode constants HLT..JMP
  - arbiter state encoding (IDLE=0, ACK=1)
- One natural sub-module, risc_sat_counter: saturating wait counter with clear/increment, parameterised by MAX_WAIT, asynchronous active-low reset.

Test Plan:
- Reset: rst=0 mid-run → all outputs 0 immediately (async); after release, no dbg_ack until a new dbg_req.
- CPU only: cpu_rd=1, cpu_addr=5, RAM[5]=0x01 → mem_rd=1, mem_addr=5 same cycle; cpu_rdata=0x01 next cycle; cpu_stall=0 throughout.
- Halted load/readback: cpu_halt=1, dbg write addr 8 data 0xA5 → mem_wr=1 at grant, dbg_ack next cycle; dbg read addr 8 → dbg_rdata=0xA5 with dbg_ack.
- Idle slot: CPU accesses on alternate cycles, dbg_req during a CPU cycle → grant in the next CPU-free cycle, ack the cycle after, cpu_stall never asserted.
- Starvation: CPU accesses every cycle with MAX_WAIT=8, dbg read addr 3 → cpu_stall=1 exactly in the 9th cycle after the request; dbg_ack next; wait_cnt back to 0.
- Write-protect (macro defined): cpu_halt=0, dbg write addr 2 → mem_wr=0, dbg_err=1 with dbg_ack, RAM[2] unchanged. Without the macro, the same stimulus writes RAM[2].
